tie_fanout_enable_sequencer: RTL and testbench

//  Staggered enable scheduler for one high-fanout constant net (tie cell driving buffer loads and PAD loads).

---
 rtl/tie_fanout_enable_sequencer.sv | 141 ++++++++++++++
 tb/tb_tie_fanout_enable_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tie_fanout_enable_sequencer.sv
// Staggered enable scheduler for a high-fanout tie net: buffer groups ramp on low->high,
// then PAD groups; ramp-down is the exact reverse. Enables are registered decodes of a step level.
module tie_fanout_enable_sequencer #(
    parameter int NUM_BUF = 92,
    parameter int NUM_PAD = 11,
    parameter int GROUP   = 8,
    parameter int STAGGER = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    output logic [NUM_BUF-1:0] buf_en,
    output logic [NUM_PAD-1:0] pad_en,
    output logic               busy,
    output logic               all_on
);

    localparam int NB  = (NUM_BUF + GROUP - 1) / GROUP;
    localparam int NP  = (NUM_PAD + GROUP - 1) / GROUP;
    localparam int TOT = NB + NP;
    localparam int LW  = $clog2(TOT + 1);
    localparam int CW  = (STAGGER > 1) ? $clog2(STAGGER) : 1;

    localparam logic [LW-1:0] LVL_MAX  = LW'(TOT);
    localparam logic [CW-1:0] CNT_WRAP = CW'(STAGGER - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_UP,
        S_ON,
        S_DOWN
    } state_t;

    state_t        r_state;
    state_t        w_stateNext;
    logic [LW-1:0] r_level;
    logic [LW-1:0] w_levelNext;
    logic [LW-1:0] w_levelInc;
    logic [LW-1:0] w_levelDec;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cntNext;
    logic          w_cntWrap;
    logic          w_goUp;

    logic [NUM_BUF-1:0] w_bufEn;
    logic [NUM_PAD-1:0] w_padEn;

    assign w_levelInc = (r_level == LVL_MAX) ? r_level : r_level + LW'(1);
    assign w_levelDec = (r_level == '0) ? r_level : r_level - LW'(1);
    assign w_cntWrap  = (r_cnt == CNT_WRAP);
    assign w_goUp     = start && !stop;

    // Any direction change takes its first step immediately and restarts the stagger count.
    always_comb begin
        w_stateNext = r_state;
        w_levelNext = r_level;
        w_cntNext   = r_cnt;
        unique case (r_state)
            S_IDLE: begin
                if (w_goUp) begin
                    w_stateNext = S_UP;
                    w_levelNext = w_levelInc;
                    w_cntNext   = '0;
                end
            end
            S_UP: begin
                if (stop) begin
                    w_stateNext = S_DOWN;
                    w_levelNext = w_levelDec;
                    w_cntNext   = '0;
                end else if (r_level == LVL_MAX) begin
                    w_stateNext = S_ON;
                    w_cntNext   = '0;
                end else if (w_cntWrap) begin
                    w_levelNext = w_levelInc;
                    w_cntNext   = '0;
                end else begin
                    w_cntNext   = r_cnt + CW'(1);
                end
            end
            S_ON: begin
                if (stop) begin
                    w_stateNext = S_DOWN;
                    w_levelNext = w_levelDec;
                    w_cntNext   = '0;
                end
            end
            S_DOWN: begin
                if (w_goUp) begin
                    w_stateNext = S_UP;
                    w_levelNext = w_levelInc;
                    w_cntNext   = '0;
                end else if (r_level == '0) begin
                    w_stateNext = S_IDLE;
                    w_cntNext   = '0;
                end else if (w_cntWrap) begin
                    w_levelNext = w_levelDec;
                    w_cntNext   = '0;
                end else begin
                    w_cntNext   = r_cnt + CW'(1);
                end
            end
            default: begin
                w_stateNext = S_IDLE;
                w_levelNext = '0;
                w_cntNext   = '0;
            end
        endcase
    end

    // Group g of buffers is on once the level passes g; PAD groups follow all buffer groups.
    for (genvar gi = 0; gi < NUM_BUF; gi++) begin : g_buf
        assign w_bufEn[gi] = (LW'(gi / GROUP) < w_levelNext);
    end

    for (genvar gj = 0; gj < NUM_PAD; gj++) begin : g_pad
        assign w_padEn[gj] = (LW'(NB + gj / GROUP) < w_levelNext);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_level <= '0;
            r_cnt   <= '0;
            buf_en  <= '0;
            pad_en  <= '0;
            busy    <= 1'b0;
            all_on  <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_level <= w_levelNext;
            r_cnt   <= w_cntNext;
            buf_en  <= w_bufEn;
            pad_en  <= w_padEn;
            busy    <= (w_stateNext == S_UP) || (w_stateNext == S_DOWN);
            all_on  <= (w_stateNext == S_ON);
        end
    end

endmodule

// File: tb/tb_tie_fanout_enable_sequencer.sv
// Directed bench for tie_fanout_enable_sequencer at default parameters (NB=12, NP=2, STAGGER=4).
// Cycle n is the interval after the n-th sampling edge; inputs set during cycle n are sampled at its end.
module tb_tie_fanout_enable_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic        stop;
    logic [91:0] buf_en;
    logic [10:0] pad_en;
    logic        busy;
    logic        all_on;

    int vectors;
    int miscompares;
    int cyc;

    tie_fanout_enable_sequencer #(
        .NUM_BUF(92),
        .NUM_PAD(11),
        .GROUP  (8),
        .STAGGER(4)
    ) u_dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .stop  (stop),
        .buf_en(buf_en),
        .pad_en(pad_en),
        .busy  (busy),
        .all_on(all_on)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [91:0] bufMask(input int lvl);
        logic [91:0] m;
        m = '0;
        for (int i = 0; i < 92; i++) if ((i / 8) < lvl) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [10:0] padMask(input int lvl);
        logic [10:0] m;
        m = '0;
        for (int j = 0; j < 11; j++) if ((12 + j / 8) < lvl) m[j] = 1'b1;
        return m;
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
        cyc++;
    endtask

    task automatic doReset();
        rst = 1'b1; start = 1'b0; stop = 1'b0;
        step();
        step();
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; stop = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            vectors++;
            if ({busy, all_on, pad_en, buf_en} !== '0) begin
                miscompares++;
                $display("[TB] FAIL reset k=%0d got busy=%b on=%b pad=%h buf=%h exp all zero",
                         k, busy, all_on, pad_en, buf_en);
            end
        end
        start = 1'b0; rst = 1'b0;
        step();
        vectors++;
        if ({busy, all_on, pad_en, buf_en} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_release got busy=%b on=%b pad=%h buf=%h exp all zero",
                     busy, all_on, pad_en, buf_en);
        end
    endtask

    task automatic test_ramp_up();
        int lvl;
        logic [104:0] exp;
        doReset();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 58; c++) begin
            if (c > 1) step();
            lvl = (c >= 53) ? 14 : ((c - 1) / 4 + 1);
            exp = {(c <= 53), (c >= 54), padMask(lvl), bufMask(lvl)};
            vectors++;
            if ({busy, all_on, pad_en, buf_en} !== exp) begin
                miscompares++;
                $display("[TB] FAIL ramp_up c=%0d got=%h exp=%h", c,
                         {busy, all_on, pad_en, buf_en}, exp);
            end
            if (c == 44 || c == 45) begin
                vectors++;
                if (buf_en[91:88] !== ((c == 45) ? 4'hF : 4'h0)) begin
                    miscompares++;
                    $display("[TB] FAIL ramp_up_lastbuf c=%0d got=%h", c, buf_en[91:88]);
                end
            end
        end
    endtask

    // Continues from the settled ON state left by test_ramp_up.
    task automatic test_ramp_down();
        int lvl;
        logic [104:0] exp;
        logic [102:0] prev;
        prev = {pad_en, buf_en};
        stop = 1'b1;
        step();
        stop = 1'b0;
        for (int k = 1; k <= 56; k++) begin
            if (k > 1) step();
            lvl = (k <= 53) ? (14 - ((k - 1) / 4 + 1)) : 0;
            exp = {(k <= 53), 1'b0, padMask(lvl), bufMask(lvl)};
            vectors++;
            if ({busy, all_on, pad_en, buf_en} !== exp) begin
                miscompares++;
                $display("[TB] FAIL ramp_down T+%0d got=%h exp=%h", k,
                         {busy, all_on, pad_en, buf_en}, exp);
            end
            vectors++;
            if (({pad_en, buf_en} & ~prev) !== '0) begin
                miscompares++;
                $display("[TB] FAIL ramp_down_monotonic T+%0d got=%h prev=%h", k,
                         {pad_en, buf_en}, prev);
            end
            prev = {pad_en, buf_en};
        end
    endtask

    task automatic test_reversal();
        int lvl;
        doReset();
        start = 1'b1;
        step();
        start = 1'b0;
        while (cyc < 10) step();
        vectors++;
        if (buf_en !== bufMask(3)) begin
            miscompares++;
            $display("[TB] FAIL rev_level3 got=%h exp=%h", buf_en, bufMask(3));
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        for (int c = 11; c <= 22; c++) begin
            if (c > 11) step();
            lvl = (c < 15) ? 2 : ((c < 19) ? 1 : 0);
            vectors++;
            if ({busy, buf_en} !== {(c <= 19), bufMask(lvl)}) begin
                miscompares++;
                $display("[TB] FAIL rev_down c=%0d got=%b/%h exp=%b/%h", c, busy, buf_en,
                         (c <= 19), bufMask(lvl));
            end
        end

        doReset();
        start = 1'b1;
        step();
        start = 1'b0;
        while (cyc < 9) step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        step();
        step();
        vectors++;
        if (buf_en !== bufMask(2)) begin
            miscompares++;
            $display("[TB] FAIL rev_down_c12 got=%h exp=%h", buf_en, bufMask(2));
        end
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 13; c <= 17; c++) begin
            if (c > 13) step();
            lvl = (c < 17) ? 3 : 4;
            vectors++;
            if ({busy, buf_en} !== {1'b1, bufMask(lvl)}) begin
                miscompares++;
                $display("[TB] FAIL rev_up c=%0d got=%b/%h exp=1/%h", c, busy, buf_en, bufMask(lvl));
            end
        end
    endtask

    task automatic test_simultaneous();
        doReset();
        start = 1'b1; stop = 1'b1;
        step();
        step();
        start = 1'b0;
        step();
        stop = 1'b0;
        vectors++;
        if ({busy, all_on, pad_en, buf_en} !== '0) begin
            miscompares++;
            $display("[TB] FAIL both_idle got busy=%b buf=%h exp idle", busy, buf_en);
        end

        doReset();
        start = 1'b1;
        step();
        start = 1'b0;
        while (cyc < 5) step();
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        vectors++;
        if ({busy, all_on, buf_en} !== {1'b1, 1'b0, bufMask(1)}) begin
            miscompares++;
            $display("[TB] FAIL both_up got=%b%b/%h exp=10/%h", busy, all_on, buf_en, bufMask(1));
        end

        doReset();
        start = 1'b1;
        step();
        start = 1'b0;
        while (cyc < 58) step();
        start = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            vectors++;
            if ({busy, all_on, pad_en, buf_en} !== {2'b01, padMask(14), bufMask(14)}) begin
                miscompares++;
                $display("[TB] FAIL start_in_on k=%0d got=%h", k, {busy, all_on, pad_en, buf_en});
            end
        end
        stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        vectors++;
        if ({busy, all_on, pad_en} !== {2'b10, 11'h0FF}) begin
            miscompares++;
            $display("[TB] FAIL both_on got=%b%b/%h exp=10/0ff", busy, all_on, pad_en);
        end
        for (int k = 0; k < 4; k++) step();
        vectors++;
        if ({pad_en, buf_en} !== {padMask(12), bufMask(12)}) begin
            miscompares++;
            $display("[TB] FAIL both_on_next got=%h exp=%h", {pad_en, buf_en},
                     {padMask(12), bufMask(12)});
        end
    endtask

    task automatic test_reset_mid();
        doReset();
        start = 1'b1;
        step();
        start = 1'b0;
        while (cyc < 20) step();
        vectors++;
        if (buf_en !== bufMask(5)) begin
            miscompares++;
            $display("[TB] FAIL rstmid_pre got=%h exp=%h", buf_en, bufMask(5));
        end
        rst = 1'b1;
        step();
        vectors++;
        if ({busy, all_on, pad_en, buf_en} !== '0) begin
            miscompares++;
            $display("[TB] FAIL rstmid_edge got=%h exp=0", {busy, all_on, pad_en, buf_en});
        end
        rst = 1'b0;
        step();
        vectors++;
        if ({busy, pad_en, buf_en} !== '0) begin
            miscompares++;
            $display("[TB] FAIL rstmid_release got=%h exp=0", {busy, pad_en, buf_en});
        end
        start = 1'b1;
        step();
        start = 1'b0;
        vectors++;
        if ({busy, buf_en} !== {1'b1, bufMask(1)}) begin
            miscompares++;
            $display("[TB] FAIL rstmid_restart got=%b/%h exp=1/%h", busy, buf_en, bufMask(1));
        end
        for (int k = 0; k < 4; k++) step();
        vectors++;
        if (buf_en !== bufMask(2)) begin
            miscompares++;
            $display("[TB] FAIL rstmid_step1 got=%h exp=%h", buf_en, bufMask(2));
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        cyc = 0;
        rst = 1'b1;
        start = 1'b0;
        stop = 1'b0;
        test_reset();
        test_ramp_up();
        test_ramp_down();
        test_reversal();
        test_simultaneous();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
